// File: rtl/loader_pkg.sv
// Shared types for the UART boot-time program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      DONE,
      ERROR
   } loader_state_t;

   localparam int LOADER_HDR_BYTES = 4;

   typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/byte_assembler.sv
// Collects four UART bytes into one little-endian 32-bit word.
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        strobe,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   lane_idx_t   idx_q, idx_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d  = '0;
         word_d = '0;
      end else if (strobe) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_in;
         idx_d = idx_q + 2'd1;
      end
   end

   // The word is presented combinationally so it is usable on the 4th strobe.
   assign word       = word_d;
   assign word_valid = strobe & ~clear & (idx_q == lane_idx_t'(LOADER_HDR_BYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: UART byte stream (word count N, then N LE words) into imem from address 0.
//  state | meaning
//  IDLE  | waiting for rising edge of flash
//  HDR   | assembling the 4-byte word count
//  DATA  | assembling and writing instruction words
//  DONE  | one-cycle completion pulse
//  ERROR | oversize, timeout or abort; held until flash falls
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flash,
   input  logic                  uart_received,
   input  logic [7:0]            uart_data,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int          TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] DEPTH_W = 32'(2 ** ADDR_WIDTH);

   loader_state_t         state_q, state_d;
   logic                  flash_q;
   logic [ADDR_WIDTH:0]   n_q, n_d;
   logic [ADDR_WIDTH:0]   wl_q, wl_d, wl_inc;
   logic [TMO_W-1:0]      tmo_q, tmo_d, tmo_inc;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  load_done_q, load_done_d;
   logic                  load_error_q, load_error_d;

   logic                  start, loading, timeout;
   logic                  asm_clear, asm_strobe, word_valid;
   logic [31:0]           word;

   assign loading    = (state_q == HDR) || (state_q == DATA);
   assign asm_clear  = ~loading;
   assign asm_strobe = uart_received & loading;

   byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (asm_clear),
      .strobe     (asm_strobe),
      .byte_in    (uart_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_comb begin
      start   = flash & ~flash_q;
      tmo_inc = tmo_q + 1'b1;
      wl_inc  = wl_q + 1'b1;
      // Expiry when the idle count would reach TIMEOUT_CYCLES-1; a strobe that cycle wins.
      timeout = loading & ~uart_received & (tmo_inc == TMO_W'(TIMEOUT_CYCLES - 1));

      state_d      = state_q;
      n_d          = n_q;
      wl_d         = wl_q;
      tmo_d        = tmo_q;
      imem_we_d    = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      load_error_d = load_error_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = HDR;
               load_error_d = 1'b0;
               wl_d         = '0;
               tmo_d        = '0;
            end
         end
         HDR: begin
            if (!flash || timeout) begin
               state_d = ERROR;
            end else begin
               tmo_d = uart_received ? '0 : tmo_inc;
               if (word_valid) begin
                  if (word == 32'd0) begin
                     state_d = DONE;
                  end else if (word > DEPTH_W) begin
                     state_d = ERROR;
                  end else begin
                     n_d     = word[ADDR_WIDTH:0];
                     state_d = DATA;
                  end
               end
            end
         end
         DATA: begin
            if (!flash || timeout) begin
               state_d = ERROR;
            end else begin
               tmo_d = uart_received ? '0 : tmo_inc;
               if (word_valid) begin
                  imem_we_d = 1'b1;
                  addr_d    = wl_q[ADDR_WIDTH-1:0];
                  wdata_d   = word;
                  wl_d      = wl_inc;
                  if (wl_inc == n_q) begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ERROR: begin
            if (!flash) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == ERROR) begin
         load_error_d = 1'b1;
      end
      load_done_d = (state_d == DONE);
      cpu_hold_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         flash_q      <= 1'b0;
         n_q          <= '0;
         wl_q         <= '0;
         tmo_q        <= '0;
         imem_we_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_hold_q   <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flash_q      <= flash;
         n_q          <= n_d;
         wl_q         <= wl_d;
         tmo_q        <= tmo_d;
         imem_we_q    <= imem_we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign load_done    = load_done_q;
   assign load_error   = load_error_q;
   assign words_loaded = wl_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed scoreboard bench for uart_program_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=16).
module tb_uart_program_loader;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flash = 1'b0;
   logic          uart_received = 1'b0;
   logic [7:0]    uart_data = 8'h00;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          load_error;
   logic [AW:0]   words_loaded;

   uart_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .flash         (flash),
      .uart_received (uart_received),
      .uart_data     (uart_data),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .cpu_hold      (cpu_hold),
      .load_done     (load_done),
      .load_error    (load_error),
      .words_loaded  (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every write pulse is popped against the scoreboard.
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: actual addr=%0d data=%h required no write", imem_addr, imem_wdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_addr", 64'(imem_addr), 64'(e.addr));
            chk("write_data", 64'(imem_wdata), 64'(e.data));
            chk("write_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (load_done) done_cnt++;
   end

   // All tasks assume entry at posedge+1 and return at posedge+1.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      uart_received = 1'b1;
      uart_data     = b;
      @(posedge clk);
      #1;
      uart_received = 1'b0;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic send_hdr(input logic [31:0] n);
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
      for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
      push_exp(a, w);
      send_byte(w[31:24]);
   endtask

   task automatic start_load();
      flash = 1'b1;
      idle(1);
   endtask

   task automatic end_load();
      flash = 1'b0;
      idle(2);
   endtask

   logic [31:0] prog [3];
   int          d0;

   initial begin
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0010_0113;
      prog[2] = 32'h0020_81B3;

      #2;
      chk("reset_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error, words_loaded}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      chk("idle_hold", 64'(cpu_hold), 64'd0);

      // Normal 3-word load
      d0 = done_cnt;
      start_load();
      chk("hold_after_start", 64'(cpu_hold), 64'd1);
      send_hdr(32'd3);
      for (int i = 0; i < 3; i++) send_word(prog[i], AW'(i));
      idle(2);
      chk("load3_done", 64'(done_cnt - d0), 64'd1);
      chk("load3_words", 64'(words_loaded), 64'd3);
      chk("load3_hold", 64'(cpu_hold), 64'd0);
      chk("load3_err", 64'(load_error), 64'd0);
      end_load();

      // Zero-length header
      d0 = done_cnt;
      start_load();
      send_hdr(32'd0);
      idle(2);
      chk("zero_done", 64'(done_cnt - d0), 64'd1);
      chk("zero_err", 64'(load_error), 64'd0);
      chk("zero_words", 64'(words_loaded), 64'd0);
      chk("zero_hold", 64'(cpu_hold), 64'd0);
      end_load();

      // Oversize header N = DEPTH+1
      d0 = done_cnt;
      start_load();
      send_hdr(32'h0000_0011);
      idle(3);
      chk("over_err", 64'(load_error), 64'd1);
      chk("over_hold", 64'(cpu_hold), 64'd1);
      chk("over_nodone", 64'(done_cnt - d0), 64'd0);
      flash = 1'b0;
      idle(1);
      chk("over_release", 64'(cpu_hold), 64'd0);
      chk("over_sticky", 64'(load_error), 64'd1);
      idle(1);

      // Timeout after 15 idle cycles
      start_load();
      chk("restart_clears_err", 64'(load_error), 64'd0);
      send_hdr(32'd2);
      send_word(32'hDEAD_BEEF, 4'd0);
      send_byte(8'h55);
      idle(14);
      chk("tmo_not_yet", 64'(load_error), 64'd0);
      idle(1);
      chk("tmo_err", 64'(load_error), 64'd1);
      chk("tmo_words", 64'(words_loaded), 64'd1);
      end_load();

      // Byte on the expiry cycle is accepted
      d0 = done_cnt;
      start_load();
      send_hdr(32'd1);
      send_byte(8'h78);
      idle(14);
      send_byte(8'h56);
      idle(14);
      send_byte(8'h34);
      push_exp(4'd0, 32'h1234_5678);
      send_byte(8'h12);
      idle(2);
      chk("expiry_no_err", 64'(load_error), 64'd0);
      chk("expiry_done", 64'(done_cnt - d0), 64'd1);
      end_load();

      // Abort after 2 data bytes
      start_load();
      send_hdr(32'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      flash = 1'b0;
      idle(1);
      chk("abort_err", 64'(load_error), 64'd1);
      chk("abort_hold", 64'(cpu_hold), 64'd1);
      idle(1);
      chk("abort_idle", 64'(cpu_hold), 64'd0);
      chk("abort_words", 64'(words_loaded), 64'd0);
      idle(1);
      start_load();
      chk("abort_restart_clr", 64'(load_error), 64'd0);

      // Async reset on the 4th byte of word 1
      send_hdr(32'd2);
      send_word(32'hCAFE_0001, 4'd0);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      uart_received = 1'b1;
      uart_data     = 8'h04;
      #2;
      rst = 1'b1;
      #1;
      chk("reset_mid_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error, words_loaded}, 64'd0);
      @(posedge clk);
      #1;
      chk("reset_no_we", 64'(imem_we), 64'd0);
      uart_received = 1'b0;
      flash = 1'b0;
      rst = 1'b0;
      idle(2);

      // Full memory: N == DEPTH
      d0 = done_cnt;
      start_load();
      send_hdr(32'd16);
      for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + 32'(i), AW'(i));
      idle(2);
      chk("full_done", 64'(done_cnt - d0), 64'd1);
      chk("full_words", 64'(words_loaded), 64'd16);
      chk("full_err", 64'(load_error), 64'd0);
      chk("full_hold", 64'(cpu_hold), 64'd0);
      end_load();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
